// File: rtl/mem_stage_ctrl.sv
// MM-stage data-memory access sequencer: req/ack handshake with timeout abort,
// MM->WB register enable/flush, upstream stall, sticky fault flag and stall counter.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_MM,
    input  logic        mem_acc_MM,
    input  logic        mem_rw_MM,
    input  logic        dmem_ack,
    input  logic        fault_clr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        stall_pipe,
    output logic        mmwb_enable,
    output logic        mmwb_flush,
    output logic        mem_fault,
    output logic [31:0] stall_count,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t            r_state;
    logic [TO_W-1:0]   r_timer;
    logic              r_we_q;
    logic              r_mem_fault;
    logic [31:0]       r_stall_count;

    logic w_go;
    logic w_req;
    logic w_we;
    logic w_stall;
    logic w_en;
    logic w_flush;

    assign w_go = valid_MM & mem_acc_MM;

    // Output decode; only the IDLE stall reacts combinationally to the incoming access.
    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_stall = 1'b0;
        w_en    = 1'b1;
        w_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_go;
                w_en    = ~w_go;
            end
            S_REQ, S_WAIT: begin
                w_req   = 1'b1;
                w_we    = r_we_q;
                w_stall = 1'b1;
                w_en    = 1'b0;
            end
            S_DONE:  w_flush = 1'b0;
            S_ABORT: w_flush = 1'b1;
            default: w_flush = 1'b0;
        endcase
    end

    // Access sequencer; an ack in WAIT takes priority over the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_we_q  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_we_q  <= mem_rw_MM;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= TO_W'(1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        r_state <= S_DONE;
                    end else if (r_timer == TO_W'(TIMEOUT - 1)) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_timer <= r_timer + TO_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky timeout flag; setting beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_fault <= 1'b0;
        end else if (r_state == S_ABORT) begin
            r_mem_fault <= 1'b1;
        end else if (fault_clr) begin
            r_mem_fault <= 1'b0;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 32'd0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign dmem_req    = w_req;
    assign dmem_we     = w_we;
    assign stall_pipe  = w_stall;
    assign mmwb_enable = w_en;
    assign mmwb_flush  = w_flush;
    assign mem_fault   = r_mem_fault;
    assign stall_count = r_stall_count;
    assign state_o     = r_state;

endmodule
